// File: rtl/ram_burst_reader_if.sv
// ram_burst_reader_if: burst request, RAM read port and output stream of the burst reader
interface ram_burst_reader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH = 10
);
  logic iStart;
  logic [ADDR_WIDTH-1:0] iStartAddress;
  logic [LEN_WIDTH-1:0] iLength;
  logic oBusy;
  logic [ADDR_WIDTH-1:0] oReadAddress;
  logic [DATA_WIDTH-1:0] iRamData;
  logic [DATA_WIDTH-1:0] oData;
  logic oValid;
  logic iReady;
  logic oDone;
  modport slave (
    input iStart, iStartAddress, iLength, iRamData, iReady,
    output oBusy, oReadAddress, oData, oValid, oDone
  );
  modport master (
    output iStart, iStartAddress, iLength, iRamData, iReady,
    input oBusy, oReadAddress, oData, oValid, oDone
  );
endinterface

// File: rtl/ram_burst_reader.sv
// ram_burst_reader: issues RAM reads for a burst and streams the words through a 2-entry buffer
module ram_burst_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH = 10
) (
  input logic Clock,
  input logic Reset,
  ram_burst_reader_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] addr, last_addr;
  logic [LEN_WIDTH-1:0] remaining;
  logic [DATA_WIDTH-1:0] mem [2];
  logic [1:0] count, count_nx;
  logic rd_ptr, wr_ptr, inflight, done, done_nx;
  logic valid, pop, issue, accept;
  assign valid = count != 2'd0;
  assign bus.oValid = valid;
  assign bus.oData = valid ? mem[rd_ptr] : '0;
  assign bus.oBusy = state != IDLE;
  assign bus.oDone = done;
  assign bus.oReadAddress = issue ? addr : last_addr;
  always_ff @(posedge Clock)
    if (Reset) state <= IDLE;
    else state <= state_nx;
  // credit = 2 - buffered - inflight + pop must stay positive to issue
  always_comb begin
    pop = valid && bus.iReady;
    issue = state == RUN && ({1'b0, count} + {2'b0, inflight}) < (3'd2 + {2'b0, pop});
    count_nx = count + {1'b0, inflight} - {1'b0, pop};
    accept = state == IDLE && bus.iStart;
    state_nx = state;
    done_nx = 1'b0;
    if (accept) begin
      state_nx = bus.iLength == '0 ? IDLE : RUN;
      done_nx = bus.iLength == '0;
    end else if (issue && remaining == LEN_WIDTH'(1)) begin
      state_nx = DRAIN;
    end else if (state == DRAIN && !inflight && count_nx == 2'd0) begin
      state_nx = IDLE;
      done_nx = 1'b1;
    end
  end
  always_ff @(posedge Clock)
    if (Reset) begin
      addr <= '0;
      last_addr <= '0;
      remaining <= '0;
      mem <= '{default: '0};
      count <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      inflight <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= done_nx;
      inflight <= issue;
      count <= count_nx;
      if (accept) begin
        addr <= bus.iStartAddress;
        remaining <= bus.iLength;
      end
      if (issue) begin
        addr <= addr + ADDR_WIDTH'(1);
        remaining <= remaining - LEN_WIDTH'(1);
        last_addr <= addr;
      end
      if (inflight) begin
        mem[wr_ptr] <= bus.iRamData;
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
    end
endmodule

// File: tb/tb_ram_burst_reader.sv
// tb_ram_burst_reader: directed bursts with a data scoreboard and per-cycle timing checks
module tb_ram_burst_reader;
  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic [7:0] ram [1024];
  logic [7:0] ram_q;
  logic [7:0] exp_q [$];
  int tests = 0;
  int fails = 0;
  int cur_k = 0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  ram_burst_reader_if #(.DATA_WIDTH(8), .ADDR_WIDTH(10), .LEN_WIDTH(10)) bus ();
  ram_burst_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(10), .LEN_WIDTH(10)) dut (
    .Clock(Clock), .Reset(Reset), .bus(bus)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) ram_q <= ram[bus.oReadAddress];
  assign bus.iRamData = ram_q;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cur_k, act, exp);
    end
  endtask

  // scoreboard monitor: every handshake pops one expected word
  always @(negedge Clock) begin
    if (Reset) prev_stall = 1'b0;
    else begin
      if (prev_stall) begin
        check("hold_valid", int'(bus.oValid), 1);
        check("hold_data", int'(bus.oData), int'(prev_data));
      end
      if (bus.oValid && bus.iReady) begin
        if (exp_q.size() == 0) check("extra_word_qsize", exp_q.size(), 1);
        else check("data", int'(bus.oData), int'(exp_q.pop_front()));
      end
      prev_stall = bus.oValid && !bus.iReady;
      prev_data = bus.oData;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic run_std(input logic [9:0] base, input int n, input bit glitch);
    logic [9:0] a;
    bus.iStart = 1'b1;
    bus.iStartAddress = base;
    bus.iLength = 10'(n);
    bus.iReady = 1'b1;
    for (int i = 0; i < n; i++) begin
      a = base + 10'(i);
      exp_q.push_back(ram[a]);
    end
    for (int k = 0; k <= n + 4; k++) begin
      cur_k = k;
      @(negedge Clock);
      if (k >= 1) begin
        a = base + 10'(k <= n ? k - 1 : n - 1);
        check("addr", int'(bus.oReadAddress), int'(a));
      end
      check("busy", int'(bus.oBusy), int'(k >= 1 && k <= n + 2));
      check("valid", int'(bus.oValid), int'(k >= 3 && k <= n + 2));
      check("done", int'(bus.oDone), int'(k == n + 3));
      @(posedge Clock);
      #1;
      bus.iStart = glitch && k + 1 == 2;
      if (glitch) begin
        bus.iStartAddress = 10'h080;
        bus.iLength = 10'd3;
      end
    end
  endtask

  initial begin
    logic [9:0] ea;
    for (int i = 0; i < 1024; i++) ram[i] = 8'(i * 7 + 3);
    ram[10'h010] = 8'hA0;
    ram[10'h011] = 8'hA1;
    ram[10'h012] = 8'hA2;
    ram[10'h013] = 8'hA3;
    bus.iStart = 1'b0;
    bus.iStartAddress = '0;
    bus.iLength = '0;
    bus.iReady = 1'b1;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    check("rst_valid", int'(bus.oValid), 0);
    check("rst_busy", int'(bus.oBusy), 0);
    check("rst_done", int'(bus.oDone), 0);
    check("rst_data", int'(bus.oData), 0);
    check("rst_addr", int'(bus.oReadAddress), 0);
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    // plain 4-word burst
    run_std(10'h010, 4, 1'b0);
    // same burst with consumer stalled in cycles 3..8
    bus.iStart = 1'b1;
    bus.iStartAddress = 10'h010;
    bus.iLength = 10'd4;
    for (int i = 0; i < 4; i++) exp_q.push_back(ram[10'h010 + 10'(i)]);
    for (int k = 0; k <= 14; k++) begin
      cur_k = k;
      @(negedge Clock);
      ea = k == 0 ? 10'h013 : k == 1 ? 10'h010 : k <= 8 ? 10'h011 : k == 9 ? 10'h012 : 10'h013;
      check("stall_addr", int'(bus.oReadAddress), int'(ea));
      check("stall_busy", int'(bus.oBusy), int'(k >= 1 && k <= 12));
      check("stall_valid", int'(bus.oValid), int'(k >= 3 && k <= 12));
      check("stall_done", int'(bus.oDone), int'(k == 13));
      if (k >= 3 && k <= 9) check("stall_head", int'(bus.oData), 32'hA0);
      @(posedge Clock);
      #1;
      bus.iStart = 1'b0;
      bus.iReady = !(k + 1 >= 3 && k + 1 <= 8);
    end
    // zero-length request
    bus.iStart = 1'b1;
    bus.iStartAddress = 10'h055;
    bus.iLength = 10'd0;
    for (int k = 0; k <= 4; k++) begin
      cur_k = k;
      @(negedge Clock);
      check("len0_addr", int'(bus.oReadAddress), 32'h013);
      check("len0_valid", int'(bus.oValid), 0);
      check("len0_busy", int'(bus.oBusy), 0);
      check("len0_done", int'(bus.oDone), int'(k == 1));
      @(posedge Clock);
      #1;
      bus.iStart = 1'b0;
    end
    // address wrap
    run_std(10'h3FE, 4, 1'b0);
    // reset mid-burst
    bus.iStart = 1'b1;
    bus.iStartAddress = 10'h020;
    bus.iLength = 10'd8;
    for (int i = 0; i < 8; i++) exp_q.push_back(ram[10'h020 + 10'(i)]);
    for (int k = 0; k <= 9; k++) begin
      cur_k = k;
      @(negedge Clock);
      if (k >= 1 && k <= 3) check("rb_addr", int'(bus.oReadAddress), 32'h020 + k - 1);
      if (k >= 5) begin
        check("rb_valid", int'(bus.oValid), 0);
        check("rb_busy", int'(bus.oBusy), 0);
        check("rb_done", int'(bus.oDone), 0);
        check("rb_addr0", int'(bus.oReadAddress), 0);
      end
      @(posedge Clock);
      #1;
      bus.iStart = 1'b0;
      Reset = k + 1 == 4;
      if (k + 1 == 5) exp_q.delete();
    end
    run_std(10'h030, 2, 1'b0);
    // iStart during an active burst is ignored
    run_std(10'h040, 4, 1'b1);
    @(negedge Clock);
    cur_k = -1;
    check("drained_qsize", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ram_burst_reader.md
# ram_burst_reader

Burst read sequencer that sits directly downstream of the single-read-port RAM. An upstream requester supplies a start address and word count. The block drives the RAM read address, tracks the RAM's one-cycle read latency, and streams the returned words to a consumer over a valid/ready handshake. A 2-entry output buffer absorbs consumer backpressure without losing in-flight reads, and sustains one word per cycle when the consumer never stalls.

## Interface
- DATA_WIDTH, 8, word width; matches the RAM data width.
- ADDR_WIDTH, 10, RAM address width.
- LEN_WIDTH, 10, width of the burst length field.
- Clock  in  1  clock; all logic is rising-edge.
- Reset  in  1  reset; synchronous, active-high; clock Clock.
- iStart  in  1  burst request; sampled only in IDLE.
- iStartAddress  in  ADDR_WIDTH  first word address; captured with iStart.
- iLength  in  LEN_WIDTH  number of words; captured with iStart; 0 is legal.
- oBusy  out  1  high from the cycle after an accepted iStart until the burst completes.
- oReadAddress  out  ADDR_WIDTH  connects to the RAM read address.
- iRamData  in  DATA_WIDTH  RAM read data; valid the cycle after its address is issued.
- oData  out  DATA_WIDTH  output word.
- oValid  out  1  oData is valid.
- iReady  in  1  consumer accepts oData.
- oDone  out  1  one-cycle pulse marking the end of a burst.

## Operation
- States:
  - IDLE: waiting for a request.
  - RUN: issuing reads; remaining words > 0.
  - DRAIN: all reads issued; waiting for the in-flight read and the buffer to empty.
- IDLE transitions:
  - iStart with iLength ≠ 0: capture address and length, go to RUN.
  - iStart with iLength = 0: pulse oDone the next cycle and stay in IDLE; no reads are issued.
- A read is issued in RUN when credit > 0, where credit = 2 − buffer count − inflight + (oValid && iReady).
  - On issue: oReadAddress = current address, the address increments, remaining decrements, and the inflight flag sets for the next cycle.
- When inflight is set, iRamData is written into the buffer tail at the end of the cycle.
- After the last issue, the state goes to DRAIN.
- DRAIN completes when inflight = 0 and the buffer is empty after the final handshake. Then oDone pulses for one cycle, oBusy drops in the same cycle, and the state returns to IDLE.
- Address arithmetic is modulo 2^ADDR_WIDTH: address (2^ADDR_WIDTH − 1) wraps to 0, and the burst continues.
- oReadAddress holds its last value when no read is issued. RAM output in those cycles is ignored, since only the inflight flag qualifies iRamData.
- Buffer behaviour:
  - FIFO order; oData is the head entry; oValid = (count ≠ 0).
  - Simultaneous push and pop is allowed at any count, including count = 2.
- While oValid && !iReady, oData and oValid hold stable.
- iStart outside IDLE is ignored, with no side effects.
- Reset at any point, including mid-burst:
  - state goes to IDLE; buffer, inflight, and remaining are cleared.
  - A RAM word returning the next cycle is discarded.
  - Outputs take reset values: oBusy 0, oValid 0, oDone 0, oData 0, oReadAddress 0.
- If a RAM write hits the address being read in the same cycle, the RAM returns the newly written data. The block forwards it unchanged.

## Timing
- Cycle numbering below is relative to the iStart cycle (cycle 0).
- iStart is sampled in cycle 0. oBusy = 1 from cycle 1.
- The first address is driven in cycle 1. iRamData is valid in cycle 2. The first oValid is in cycle 3, giving 3-cycle latency.
- With iReady held at 1, one word is delivered per cycle. For N words, the last handshake is in cycle N+2 and oDone pulses in cycle N+3 with oBusy = 0.
- A new iStart is accepted in the oDone cycle.
- With iLength = 0, oDone pulses in cycle 1, and oBusy stays 0 throughout.
- After backpressure releases, throughput resumes at 1 word per cycle with no bubbles beyond buffer refill.

## Test plan
- RAM[0x10..0x13] = A0..A3; start 0x10, length 4, iReady = 1 → oValid in cycles 3–6 with A0..A3, oDone in cycle 7, addresses 0x10..0x13 in cycles 1–4.
- Same burst with iReady = 0 during cycles 3–8, then 1 → at most 2 reads outstanding; oData = A0 held stable; all 4 words delivered in order with none lost or duplicated.
- Length 0 at address 0x55 → no change on oReadAddress, oValid never asserts, oDone pulses in cycle 1.
- Start 0x3FE, length 4 (ADDR_WIDTH = 10) → addresses 0x3FE, 0x3FF, 0x000, 0x001; data in that order.
- Reset asserted in cycle 4 of an 8-word burst → next cycle oValid 0, oBusy 0, oReadAddress 0; no oDone pulse; a subsequent 2-word burst completes correctly.
- iStart pulsed in cycle 2 of an active burst with a different address → ignored; the original burst completes unchanged.
